// File: rtl/mem_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mem_write_buffer
// Brief    : Posted-write FIFO between cache and main memory with read-hit
//            forwarding; read misses bypass queued writes.
// Revision : 1.0 - initial release
// ============================================================================
module mem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              up_valid,
    input  logic              up_rw,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic [LINE_W-1:0] up_wdata,
    output logic              up_ready,
    output logic [LINE_W-1:0] up_rdata,
    output logic              mem_valid,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {U_IDLE, U_RESP, U_RDWAIT} u_state_t;
    typedef enum logic [1:0] {M_IDLE, M_WRITE, M_READ} m_state_t;

    u_state_t            r_ustate;
    m_state_t            r_mstate;
    logic [ADDR_W-1:0]   r_fifo_addr [DEPTH];
    logic [LINE_W-1:0]   r_fifo_data [DEPTH];
    logic [c_PTR_W-1:0]  r_head;
    logic [c_PTR_W-1:0]  r_tail;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_rd_pend;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_up_ready;
    logic [LINE_W-1:0]   r_up_rdata;
    logic                r_mem_rw;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [LINE_W-1:0]   r_mem_wdata;

    logic                w_full;
    logic                w_pop;
    logic                w_accept;
    logic                w_push;
    logic                w_hit;
    logic [LINE_W-1:0]   w_hit_data;

    assign w_full   = (r_count == c_CNT_W'(DEPTH));
    assign w_pop    = (r_mstate == M_WRITE) && mem_ready;
    assign w_accept = (r_ustate == U_IDLE) && up_valid && !r_up_ready;
    // A full FIFO still accepts in the cycle its head drain completes.
    assign w_push   = w_accept && up_rw && (!w_full || w_pop);

    // Walk oldest to newest so the entry nearest the tail wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((c_CNT_W'(i) < r_count) &&
                (r_fifo_addr[r_head + c_PTR_W'(i)][ADDR_W-1:4] == up_addr[ADDR_W-1:4])) begin
                w_hit      = 1'b1;
                w_hit_data = r_fifo_data[r_head + c_PTR_W'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ustate    <= U_IDLE;
            r_mstate    <= M_IDLE;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_rd_pend   <= 1'b0;
            r_rd_addr   <= '0;
            r_up_ready  <= 1'b0;
            r_up_rdata  <= '0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_addr[r_tail] <= up_addr;
                r_fifo_data[r_tail] <= up_wdata;
                r_tail              <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            case (r_ustate)
                U_IDLE: begin
                    if (w_push) begin
                        r_up_ready <= 1'b1;
                        r_ustate   <= U_RESP;
                    end else if (w_accept && !up_rw) begin
                        if (w_hit) begin
                            r_up_rdata <= w_hit_data;
                            r_up_ready <= 1'b1;
                            r_ustate   <= U_RESP;
                        end else begin
                            r_rd_pend <= 1'b1;
                            r_rd_addr <= up_addr;
                            r_ustate  <= U_RDWAIT;
                        end
                    end
                end
                U_RESP: begin
                    r_up_ready <= 1'b0;
                    r_ustate   <= U_IDLE;
                end
                U_RDWAIT: begin
                    if ((r_mstate == M_READ) && mem_ready) begin
                        r_up_rdata <= mem_rdata;
                        r_up_ready <= 1'b1;
                        r_ustate   <= U_RESP;
                    end
                end
                default: r_ustate <= U_IDLE;
            endcase

            case (r_mstate)
                M_IDLE: begin
                    if (r_rd_pend) begin
                        r_rd_pend  <= 1'b0;
                        r_mem_rw   <= 1'b0;
                        r_mem_addr <= r_rd_addr;
                        r_mstate   <= M_READ;
                    end else if (r_count != '0) begin
                        r_mem_rw    <= 1'b1;
                        r_mem_addr  <= r_fifo_addr[r_head];
                        r_mem_wdata <= r_fifo_data[r_head];
                        r_mstate    <= M_WRITE;
                    end
                end
                M_WRITE, M_READ: begin
                    if (mem_ready) begin
                        r_mstate <= M_IDLE;
                    end
                end
                default: r_mstate <= M_IDLE;
            endcase
        end
    end

    assign up_ready  = r_up_ready;
    assign up_rdata  = r_up_rdata;
    // Masked by mem_ready so a completed request is never seen twice.
    assign mem_valid = (r_mstate != M_IDLE) && !mem_ready;
    assign mem_rw    = r_mem_rw;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
